// File: rtl/common.sv
// Shared constants, state type and helpers for the data-memory responder.
package common;

    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_type;

    // True when the low address bits do not match the natural alignment of the access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        return ((size == MEM_HALF) && lo[0]) || ((size == MEM_WORD) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load lane select and sign/zero extension for the data-memory responder.
module dmem_load_align
    import common::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] result
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Halves and words ignore the address bits below their own size.
    always_comb begin
        lane_byte = word[{addr, 3'b000} +: 8];
        lane_half = addr[1] ? word[31:16] : word[15:0];
        result    = '0;
        case (size)
            MEM_BYTE: result = {{24{sign & lane_byte[7]}}, lane_byte};
            MEM_HALF: result = {{16{sign & lane_half[15]}}, lane_half};
            MEM_WORD: result = word;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request, fixed wait states, held response.
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module dmem_responder
    import common::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) * 33'd4;

    dmem_state_type state;
    logic [3:0]     count;

    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        lat_read;
    logic        lat_write;
    logic [1:0]  lat_size;
    logic        lat_sign;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          enter_resp;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic          acc_read;
    logic          acc_write;
    logic [1:0]    acc_size;
    logic          acc_sign;
    logic          acc_error;
    logic [AW-1:0] acc_index;
    logic [31:0]   load_result;
    logic [3:0]    lane_en;
    logic [31:0]   lane_data;

    assign accept     = req_valid && req_ready;
    assign enter_resp = !reset &&
                        (((state == IDLE) && accept && (WAIT_STATES == 0)) ||
                         ((state == WAIT) && (count == 4'd0)));

    // With zero wait states the access happens on the accept edge, so it must see the live request.
    always_comb begin
        acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
        acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;
        acc_read  = (state == IDLE) ? req_read  : lat_read;
        acc_write = (state == IDLE) ? req_write : lat_write;
        acc_size  = (state == IDLE) ? req_size  : lat_size;
        acc_sign  = (state == IDLE) ? req_sign  : lat_sign;
        acc_index = acc_addr[AW+1:2];
        acc_error = (acc_size == 2'b11) || (acc_read && acc_write) || ({1'b0, acc_addr} >= LIMIT);
`ifdef DMEM_MISALIGN_TRAP_EN
        acc_error = acc_error || is_misaligned(acc_size, acc_addr[1:0]);
`endif
    end

    always_comb begin
        lane_en   = 4'b1111;
        lane_data = acc_wdata;
        case (acc_size)
            MEM_BYTE: begin
                lane_en   = 4'b0001 << acc_addr[1:0];
                lane_data = {4{acc_wdata[7:0]}};
            end
            MEM_HALF: begin
                lane_en   = acc_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{acc_wdata[15:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                lane_data = acc_wdata;
            end
        endcase
    end

    dmem_load_align u_load_align (
        .word   (mem[acc_index]),
        .addr   (acc_addr[1:0]),
        .size   (acc_size),
        .sign   (acc_sign),
        .result (load_result)
    );

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk) begin
        if (enter_resp && acc_write && !acc_error) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_en[i]) begin
                    mem[acc_index][8*i +: 8] <= lane_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_error <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_read  <= 1'b0;
            lat_write <= 1'b0;
            lat_size  <= '0;
            lat_sign  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_read  <= req_read;
                        lat_write <= req_write;
                        lat_size  <= req_size;
                        lat_sign  <= req_sign;
                        req_ready <= 1'b0;
                        if (WAIT_STATES > 0) begin
                            state <= WAIT;
                            count <= 4'(WAIT_STATES - 1);
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                WAIT: begin
                    if (count == 4'd0) begin
                        state <= RESP;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state     <= IDLE;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_error <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_error <= acc_error;
                rsp_rdata <= (acc_read && !acc_error) ? load_result : '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: byte-array reference model, random and directed traffic.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int WS    = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_read;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_sign;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [7:0]  model_mem [4096];
    int          check_count = 0;
    int          pass_count  = 0;
    logic        hold_ready  = 1'b0;
    logic        prev_stall  = 1'b0;
    logic [31:0] prev_rdata;
    logic        prev_error;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_read  (req_read),
        .req_write (req_write),
        .req_size  (req_size),
        .req_sign  (req_sign),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_count++;
        if (act === exp) pass_count++;
        else $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Reference model: bytes, little-endian, access aligned down to its size.
    function automatic exp_t model_access(input logic [31:0] addr, input logic [31:0] wdata,
                                          input logic rd, input logic wr,
                                          input logic [1:0] size, input logic sgn);
        exp_t        r;
        int          n;
        logic [31:0] base;
        logic [31:0] val;
        r.rdata = '0;
        r.error = 1'b0;
        if (size == 2'b11 || (rd && wr) || addr >= 32'(DEPTH * 4)) begin
            r.error = 1'b1;
            return r;
        end
        n = 1 << size;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (addr % 32'(n) != 0) begin
            r.error = 1'b1;
            return r;
        end
`endif
        base = addr - (addr % 32'(n));
        if (wr) begin
            for (int i = 0; i < n; i++) model_mem[base + 32'(i)] = wdata[8*i +: 8];
        end
        if (rd) begin
            val = '0;
            for (int i = 0; i < n; i++) val = val | (32'(model_mem[base + 32'(i)]) << (8 * i));
            if (sgn && n < 4 && val >= (32'd1 << (8 * n - 1))) val = val - (32'd1 << (8 * n));
            r.rdata = val;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] addr);
        return {model_mem[addr + 3], model_mem[addr + 2], model_mem[addr + 1], model_mem[addr]};
    endfunction

    task automatic wait_ready();
        int k = 0;
        while (!req_ready && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!req_ready) checkOutput("req_ready_timeout", 32'(req_ready), 32'd1);
    endtask

    // One complete transaction; callers stay in the phase 1 time unit after a rising edge.
    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic rd, input logic wr, input logic [1:0] size,
                                 input logic sgn, input logic use_exp,
                                 input logic [31:0] exp_rdata, input logic exp_err, input int stall);
        exp_t        m;
        exp_t        e;
        int          k;
        logic [31:0] held;
        m = model_access(addr, wdata, rd, wr, size, sgn);
        if (use_exp) begin
            e.rdata = exp_rdata;
            e.error = exp_err;
        end else begin
            e = m;
        end
        wait_ready();
        if (!req_ready) return;
        if (stall > 0) hold_ready = 1'b1;
        req_addr  = addr;
        req_wdata = wdata;
        req_read  = rd;
        req_write = wr;
        req_size  = size;
        req_sign  = sgn;
        req_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 40) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput("latency", 32'(k), 32'(WS));
        checkOutput("req_ready_busy", 32'(req_ready), 32'd0);
        if (stall > 0) begin
            held = rsp_rdata;
            repeat (stall) begin
                @(posedge clk); #1;
                checkOutput("stall_valid", 32'(rsp_valid), 32'd1);
                checkOutput("stall_rdata", rsp_rdata, held);
                checkOutput("stall_req_ready", 32'(req_ready), 32'd0);
            end
            hold_ready = 1'b0;
        end
        k = 0;
        while (rsp_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (rsp_valid) checkOutput("rsp_handshake_timeout", 32'(rsp_valid), 32'd0);
    endtask

    // A store abandoned by reset while waiting must leave memory untouched.
    task automatic reset_mid_store(input logic [31:0] addr);
        logic [31:0] old;
        logic        seen;
        old = model_word(addr);
        wait_ready();
        req_addr  = addr;
        req_wdata = 32'hCAFEF00D;
        req_read  = 1'b0;
        req_write = 1'b1;
        req_size  = 2'b10;
        req_sign  = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        seen  = rsp_valid;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | rsp_valid;
        end
        checkOutput("reset_no_rsp", 32'(seen), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("ready_after_reset", 32'(req_ready), 32'd1);
        applyStimulus(addr, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, old, 1'b0, 0);
    endtask

    always @(posedge clk) begin
        #2;
        rsp_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // Monitor: compares every completed response and checks held outputs while stalled.
    always @(negedge clk) begin
        if (!reset && rsp_valid) begin
            if (prev_stall) begin
                checkOutput("hold_rdata", rsp_rdata, prev_rdata);
                checkOutput("hold_error", 32'(rsp_error), 32'(prev_error));
            end
            if (rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    checkOutput("rsp_rdata", rsp_rdata, mon_e.rdata);
                    checkOutput("rsp_error", 32'(rsp_error), 32'(mon_e.error));
                end
                prev_stall = 1'b0;
            end else begin
                prev_stall = 1'b1;
                prev_rdata = rsp_rdata;
                prev_error = rsp_error;
            end
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] addr;
        logic [1:0]  size;
        int          r;
        rsp_ready = 1'b0;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_read  = 1'b0;
        req_write = 1'b0;
        req_size  = '0;
        req_sign  = 1'b0;
        for (int i = 0; i < 4096; i++) model_mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_error", 32'(rsp_error), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("ready_after_init_reset", 32'(req_ready), 32'd1);

        for (int i = 0; i < 64; i++)
            applyStimulus(32'(i * 4), $urandom, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 32'd0, 1'b0, 0);

        applyStimulus(32'h10, 32'hDEADBEEF, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'd0, 1'b0, 0);
        applyStimulus(32'h13, 32'd0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, 32'hFFFFFFDE, 1'b0, 4);
        applyStimulus(32'h13, 32'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, 32'h000000DE, 1'b0, 0);

        applyStimulus(32'h20, 32'h11223344, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'd0, 1'b0, 0);
        applyStimulus(32'h22, 32'h00008001, 1'b0, 1'b1, 2'b01, 1'b0, 1'b1, 32'd0, 1'b0, 0);
        applyStimulus(32'h20, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'h80013344, 1'b0, 0);
        applyStimulus(32'h22, 32'd0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, 32'hFFFF8001, 1'b0, 0);

        applyStimulus(32'h10, 32'd0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b1, 32'd0, 1'b1, 0);
        applyStimulus(32'h10, 32'd0, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 32'd0, 1'b1, 0);
        applyStimulus(32'h1000, 32'd0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 32'd0, 1'b1, 0);
        applyStimulus(32'h1000, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'd0, 1'b1, 0);
        applyStimulus(32'h10, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 0);
        applyStimulus(32'h0, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'd0, 1'b0, 0);

`ifdef DMEM_MISALIGN_TRAP_EN
        applyStimulus(32'h12, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'd0, 1'b1, 0);
`else
        applyStimulus(32'h12, 32'd0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 0);
`endif
        applyStimulus(32'h30, 32'h12345678, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'd0, 1'b0, 0);

        reset_mid_store(32'h40);

        for (int n = 0; n < 200; n++) begin
            addr = 32'($urandom_range(0, 255));
            r = $urandom_range(0, 19);
            if (r == 0) addr = 32'h1000 + 32'($urandom_range(0, 4095));
            else if (r == 1) addr = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
            r = $urandom_range(0, 9);
            size = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
            r = $urandom_range(0, 7);
            applyStimulus(addr, $urandom, (r == 1) || (r >= 2 && r <= 4), (r == 1) || (r >= 5),
                          size, 1'($urandom_range(0, 1)), 1'b0, 32'd0, 1'b0, 0);
        end

        repeat (2) @(posedge clk);
        #1;
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words of storage (power of two).
REQ-002 SHALL have parameter WAIT_STATES, default 2, extra cycles between acceptance and response (0..15).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_addr  input  32  byte address.
REQ-008 SHALL have port req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 SHALL have port req_read  input  1  load request (mem_read).
REQ-010 SHALL have port req_write  input  1  store request (mem_write).
REQ-011 SHALL have port req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-012 SHALL have port req_sign  input  1  1 = sign-extend load, 0 = zero-extend.
REQ-013 SHALL have port rsp_valid  output  1  response present.
REQ-014 SHALL have port rsp_ready  input  1  requester accepts response.
REQ-015 SHALL have port rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
REQ-016 SHALL have port rsp_error  output  1  access rejected; no state changed.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL accept on req_valid && req_ready, latching addr, wdata, read, write, size, sign.
REQ-019 SHALL go IDLE->WAIT on accept when WAIT_STATES>0 (counter loaded WAIT_STATES-1), else IDLE->RESP directly.
REQ-020 SHALL decrement the counter each WAIT cycle and go WAIT->RESP when it is 0.
REQ-021 SHALL perform the array access on the transition into RESP; rsp_valid first high exactly WAIT_STATES+1 cycles after the accept edge.
REQ-022 SHALL hold rsp_valid, rsp_rdata, rsp_error stable in RESP until rsp_ready; RESP->IDLE on rsp_valid && rsp_ready.
REQ-023 SHALL not accept a new request in the cycle the response completes (one IDLE bubble minimum).
REQ-024 Store SHALL write only the addressed byte lanes: byte lane addr[1:0], half lanes {addr[1],0}+1..0, word all four.
REQ-025 Load SHALL select lane by addr[1:0] and extend by req_sign (byte: bit 7, half: bit 15).
REQ-026 SHALL flag rsp_error with no access for: req_size 11; read and write both 1; addr >= DEPTH_WORDS*4.
REQ-027 Request with read=0 and write=0 SHALL complete normally with rsp_rdata 0, rsp_error 0, no write.
REQ-028 Storage array SHALL be indexed by addr[$clog2(DEPTH_WORDS)+1:2].

Reset
REQ-029 In reset: state IDLE, counter 0, req_ready 0, rsp_valid 0, rsp_rdata 0, rsp_error 0; req_ready 1 the cycle after reset deasserts.
REQ-030 Reset mid-transaction SHALL abandon it with no response; a store not yet reached RESP SHALL not be written.
REQ-031 Storage contents SHALL not be cleared by reset.

Configuration
REQ-032 With DMEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL give rsp_error=1, no access.
REQ-033 Without DMEM_MISALIGN_TRAP_EN: low address bits below access size SHALL be ignored (access aligned down), rsp_error 0.

Structure
REQ-034 Package common SHALL gain MEM_BYTE=2'b00, MEM_HALF=2'b01, MEM_WORD=2'b10 localparams and the dmem_state_type enum (IDLE, WAIT, RESP).
REQ-035 Load lane select and extension SHALL be sub-module dmem_load_align (combinational: word, addr[1:0], size, sign -> 32-bit result).

Verification
REQ-036 Word store 0xDEADBEEF @0x10, then byte load signed @0x13 -> rsp_rdata 0xFFFFFFDE, rsp_error 0; unsigned -> 0x000000DE.
REQ-037 WAIT_STATES=2: accept at edge N -> rsp_valid first at edge N+3; rsp_ready held 0 for 4 cycles -> outputs stable, req_ready 0.
REQ-038 Half store 0x8001 @0x22 onto 0x11223344 -> word 0x80013344; signed half load @0x22 -> 0xFFFF8001.
REQ-039 req_size 11, or addr 0x1000 with DEPTH_WORDS=1024 -> rsp_error 1, rsp_rdata 0, memory unchanged on readback.
REQ-040 Word load @0x12: with DMEM_MISALIGN_TRAP_EN -> rsp_error 1; without -> contents of 0x10, rsp_error 0.
REQ-041 Store accepted then reset asserted during WAIT -> no rsp_valid, target word unchanged, req_ready 1 after reset.
